sha1_digest_serializer: RTL and testbench
=========================================

Name: sha1_digest_serializer

Overview:
- Transmit-side companion to the sha1 core. Captures each result pulse (ovalid/oid/olen/osha) from the core and re-emits it as a fixed 32-byte frame on the team's byte-stream interface (tvalid/tready/tlast/tdata).
- The result port has no backpressure, so results are buffered in an internal FIFO and dropped, with a count, on overflow.
- Typical use: feeding digests to a UART/host link.

Parameters:
- DEPTH, 4, result FIFO depth in frames (power of two, ≥2); total capacity is DEPTH+1 including the frame in the serializer.
- DROP_W, 16, width of the saturating drop counter.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rstn  in  1  asynchronous active-low reset.
- ivalid  in  1  one-cycle result strobe, connected to sha1 ovalid.
- iid  in  32  result id, connected to sha1 oid.
- ilen  in  61  message length in bytes, connected to sha1 olen.
- isha  in  160  digest, connected to sha1 osha.
- tvalid  out  1  output byte valid.
- tready  in  1  downstream ready.
- tlast  out  1  marks byte 31 of a frame.
- tdata  out  8  output byte.
- busy  out  1  high while the FIFO is non-empty or a frame is in flight.
- drop_cnt  out  DROP_W  saturating count of dropped results.

Behaviour:
- Reset: asynchronous on rstn low.
  - tvalid=0, tlast=0, tdata=0, busy=0, drop_cnt=0.
  - FIFO emptied, byte counter=0.
  - A partially sent frame is discarded and never resumed.
- Frame format, 32 bytes, big-endian, MSB first:
  - bytes 0-3: iid[31:24]..iid[7:0].
  - bytes 4-11: {3'b000, ilen} as 64 bits.
  - bytes 12-31: isha[159:152]..isha[7:0].
- Capture: on an edge with ivalid=1:
  - If the FIFO count < DEPTH, the result is written.
  - Otherwise the result is dropped and drop_cnt increments, saturating at all-ones.
  - The count is evaluated before any same-edge pop.
  - A push and a pop on the same edge leave the count unchanged.
- Serializer FSM, states IDLE and SEND.
  - IDLE: tvalid=0. When the FIFO is non-empty, pop the head into a 256-bit frame register, set byte counter=0, assert tvalid, go to SEND.
  - SEND: tdata = frame byte[counter]; tlast = (counter==31). Byte transfer happens on an edge with tvalid&tready.
  - SEND, transfer with counter<31: counter increments.
  - SEND, transfer with counter==31 and FIFO non-empty: pop and load the next frame on the same edge, counter=0, tvalid stays 1. Zero-gap frames.
  - SEND, transfer with counter==31 and FIFO empty: tvalid=0, go to IDLE.
- Latency:
  - ivalid sampled at edge k into an empty block gives tvalid=1 with byte 0 after edge k+2.
  - Sustained throughput is one byte per cycle with tready=1.
- Handshake rules:
  - While tvalid=1 and tready=0, tdata and tlast are held stable.
  - tvalid never deasserts without a transfer, except on reset.
  - tvalid does not depend combinationally on tready; all outputs are registered.
- busy = (FIFO count≠0) | (state==SEND).
- ilen bits above 60 are always transmitted as zero; there is no length check.
- FIFO pointers wrap modulo DEPTH. Full and empty are distinguished by an extra pointer bit or a count.

Test Plan:
- Single frame, tready=1: ivalid with iid=111, ilen=3, isha=a9993e364706816aba3e25717850c26c9cd0d89d.
  - tvalid rises after edge k+2.
  - Bytes out: 00 00 00 6f, 00 00 00 00 00 00 00 03, a9 99 3e 36 ... d8 9d.
  - tlast only on byte 31, then tvalid=0 and busy=0.
- Back-to-back: three results on consecutive cycles (ids 1,2,3), tready=1.
  - 96 contiguous bytes with no idle cycle, tlast at bytes 31/63/95, ids in order.
- Backpressure: random tready (~50%) over 3 frames.
  - tdata/tlast unchanged on every cycle with tvalid=1 and tready=0.
  - The byte sequence equals the tready=1 case.
- Overflow, DEPTH=4, tready=0: 7 results on consecutive cycles.
  - drop_cnt=2.
  - After raising tready, exactly 5 frames with ids of results 0-4, in order.
- Max length: ilen=2^61-1.
  - Bytes 4-11 = 1f ff ff ff ff ff ff ff.
- Reset mid-frame: deassert rstn after byte 10 is accepted.
  - tvalid=0 immediately, without waiting for clk.
  - drop_cnt=0, busy=0.
  - A new result after release gives a complete frame starting at byte 0.

Source files
------------

// File: rtl/sha1_digest_serializer.sv
// sha1_digest_serializer: buffers sha1 result pulses in a FIFO and streams each
// one out as a 32-byte big-endian frame (id, 64-bit length, digest).
module sha1_digest_serializer #(
    parameter int DEPTH  = 4,
    parameter int DROP_W = 16
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              ivalid,
    input  logic [31:0]       iid,
    input  logic [60:0]       ilen,
    input  logic [159:0]      isha,
    output logic              tvalid,
    input  logic              tready,
    output logic              tlast,
    output logic [7:0]        tdata,
    output logic              busy,
    output logic [DROP_W-1:0] drop_cnt
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    typedef enum logic {IDLE, SEND} state_t;
    state_t            state_q;
    logic [255:0]      mem_q [DEPTH];
    logic              in_vld_q;
    logic [255:0]      in_data_q;
    logic [AW-1:0]     wr_q, rd_q;
    logic [CW-1:0]     count_q;
    logic [255:0]      frame_q;
    logic [4:0]        cnt_q;
    logic              tvalid_q, tlast_q;
    logic [DROP_W-1:0] drop_q;
    logic              full, push, xfer, last, pop;
    assign full = count_q == CW'(DEPTH);
    assign push = in_vld_q & ~full;
    assign xfer = tvalid_q & tready;
    assign last = xfer & (cnt_q == 5'd31);
    assign pop  = (count_q != '0) & ((state_q == IDLE) | last);
    assign tvalid   = tvalid_q;
    assign tlast    = tlast_q;
    assign tdata    = frame_q[255:248];
    assign busy     = (count_q != '0) | (state_q == SEND);
    assign drop_cnt = drop_q;
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_q] <= in_data_q;
    end
    // Results are staged one cycle before the FIFO, so byte 0 appears two edges after capture.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= IDLE;
            in_vld_q  <= 1'b0;
            in_data_q <= '0;
            wr_q      <= '0;
            rd_q      <= '0;
            count_q   <= '0;
            frame_q   <= '0;
            cnt_q     <= '0;
            tvalid_q  <= 1'b0;
            tlast_q   <= 1'b0;
            drop_q    <= '0;
        end else begin
            in_vld_q  <= ivalid;
            in_data_q <= {iid, 3'b000, ilen, isha};
            if (push) wr_q <= wr_q + 1'b1;
            if (pop) rd_q <= rd_q + 1'b1;
            count_q <= count_q + CW'(push) - CW'(pop);
            if (in_vld_q && full && drop_q != '1) drop_q <= drop_q + 1'b1;
            // The frame register shifts left so the current byte is always its top octet.
            if (pop) begin
                frame_q  <= mem_q[rd_q];
                cnt_q    <= '0;
                tvalid_q <= 1'b1;
                tlast_q  <= 1'b0;
                state_q  <= SEND;
            end else if (last) begin
                frame_q  <= {frame_q[247:0], 8'h00};
                tvalid_q <= 1'b0;
                tlast_q  <= 1'b0;
                state_q  <= IDLE;
            end else if (xfer) begin
                frame_q <= {frame_q[247:0], 8'h00};
                cnt_q   <= cnt_q + 5'd1;
                tlast_q <= cnt_q == 5'd30;
            end
        end
    end
endmodule

// File: tb/tb_sha1_digest_serializer.sv
// tb_sha1_digest_serializer: directed and randomized frame checks against a byte-queue model.
module tb_sha1_digest_serializer;
    logic         clk = 1'b0;
    logic         rstn = 1'b0;
    logic         ivalid = 1'b0;
    logic [31:0]  iid = '0;
    logic [60:0]  ilen = '0;
    logic [159:0] isha = '0;
    logic         tvalid, tready, tlast, busy;
    logic [7:0]   tdata;
    logic [15:0]  drop_cnt;
    int tests = 0;
    int fails = 0;
    logic [7:0] exp_q[$];

    sha1_digest_serializer #(.DEPTH(4), .DROP_W(16)) dut (
        .clk(clk), .rstn(rstn), .ivalid(ivalid), .iid(iid), .ilen(ilen), .isha(isha),
        .tvalid(tvalid), .tready(tready), .tlast(tlast), .tdata(tdata),
        .busy(busy), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic void add_frame(input logic [31:0] id, input logic [60:0] len, input logic [159:0] sha);
        logic [63:0] l64;
        l64 = {3'b000, len};
        for (int i = 0; i < 4; i++) exp_q.push_back(id[31-8*i -: 8]);
        for (int i = 0; i < 8; i++) exp_q.push_back(l64[63-8*i -: 8]);
        for (int i = 0; i < 20; i++) exp_q.push_back(sha[159-8*i -: 8]);
    endfunction

    task automatic send_one(input logic [31:0] id, input logic [60:0] len, input logic [159:0] sha, input bit keep);
        ivalid = 1'b1;
        iid = id;
        ilen = len;
        isha = sha;
        if (keep) add_frame(id, len, sha);
        @(posedge clk); #1;
        ivalid = 1'b0;
    endtask

    task automatic send_rand(input logic [31:0] id, input bit keep);
        send_one(id, {$urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom, $urandom}, keep);
    endtask

    task automatic collect(input string tag, input int nbytes, input bit rnd, input bit gapless);
        int got = 0;
        int cyc = 0;
        bit started = 0;
        bit stall = 0;
        logic [7:0] pd = '0;
        logic pl = 1'b0;
        logic [7:0] e;
        while (got < nbytes && cyc < 5000) begin
            tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            @(negedge clk);
            if (stall) chk({tag, " stable"}, {tvalid, tlast, tdata}, {1'b1, pl, pd});
            if (started && gapless) chk({tag, " gap"}, tvalid, 1'b1);
            if (tvalid) begin
                started = 1;
                if (tready) begin
                    e = exp_q.pop_front();
                    chk({tag, " data"}, tdata, e);
                    chk({tag, " last"}, tlast, (got % 32) == 31);
                    got++;
                    stall = 0;
                end else begin
                    stall = 1;
                    pd = tdata;
                    pl = tlast;
                end
            end
            @(posedge clk); #1;
            cyc++;
        end
        chk({tag, " count"}, got, nbytes);
    endtask

    initial begin
        tready = 1'b1;
        #12;
        chk("reset outs", {tvalid, tlast, tdata, busy, drop_cnt}, '0);
        @(posedge clk); #1;
        rstn = 1'b1;
        @(posedge clk); #1;

        send_one(32'd111, 61'd3, 160'ha9993e364706816aba3e25717850c26c9cd0d89d, 1'b1);
        chk("lat k", tvalid, 1'b0);
        @(posedge clk); #1;
        chk("lat k+1", tvalid, 1'b0);
        @(posedge clk); #1;
        chk("lat k+2", {tvalid, tdata, busy}, {1'b1, 8'h00, 1'b1});
        collect("single", 32, 1'b0, 1'b1);
        chk("single idle", {tvalid, busy}, 2'b00);

        for (int i = 1; i <= 3; i++) send_rand(i, 1'b1);
        collect("b2b", 96, 1'b0, 1'b1);
        chk("b2b idle", {tvalid, busy}, 2'b00);

        tready = 1'b0;
        for (int i = 0; i < 3; i++) send_rand($urandom, 1'b1);
        collect("bp", 96, 1'b1, 1'b0);
        tready = 1'b1;
        @(posedge clk); #1;
        chk("bp idle", {tvalid, busy}, 2'b00);

        tready = 1'b0;
        for (int i = 0; i < 7; i++) send_rand(100 + i, i < 5);
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("ovf drop", drop_cnt, 16'd2);
        chk("ovf hold", {tvalid, busy}, 2'b11);
        collect("ovf", 160, 1'b0, 1'b1);
        chk("ovf idle", {tvalid, busy, drop_cnt}, {2'b00, 16'd2});

        send_one($urandom, '1, {$urandom, $urandom, $urandom, $urandom, $urandom}, 1'b1);
        collect("maxlen", 32, 1'b0, 1'b1);

        send_rand(32'hdead_beef, 1'b1);
        @(posedge clk); #1;
        collect("pre-rst", 11, 1'b0, 1'b0);
        exp_q.delete();
        tready = 1'b0;
        #2 rstn = 1'b0;
        #1;
        chk("rst async", {tvalid, tlast, busy, drop_cnt}, '0);
        @(posedge clk); #1;
        rstn = 1'b1;
        tready = 1'b1;
        @(posedge clk); #1;
        chk("rst idle", {tvalid, busy}, 2'b00);
        send_rand(32'h0000_0abc, 1'b1);
        collect("post-rst", 32, 1'b0, 1'b1);
        chk("post-rst q", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
